// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters and a sequential flush engine.
// Optional hit/mispredict statistics counters are enabled by defining BTB_STATS_EN.
module btb_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] current_PC,
  output logic        predict_taken,
  output logic [31:0] target_addr,
  input  logic        update_predictor,
  input  logic [31:0] update_addr,
  input  logic [31:0] update_target,
  input  logic        prediction,
  input  logic        branch_result,
  input  logic        flush_req,
  output logic        busy
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] lookup_hits,
  output logic [31:0] mispredicts
`endif
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = 30 - IDX_BITS;

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  state_t                state_reg, state_next;
  logic [IDX_BITS-1:0]   flush_idx_reg, flush_idx_next;

  logic                  valid_reg  [ENTRIES];
  logic [TAG_BITS-1:0]   tag_reg    [ENTRIES];
  logic [31:0]           target_reg [ENTRIES];
  logic [1:0]            ctr_reg    [ENTRIES];

  // Lookup path
  logic [IDX_BITS-1:0]   lk_idx;
  logic [TAG_BITS-1:0]   lk_tag;
  logic                  lk_hit;
  logic [31:0]           pc_plus4;

  assign lk_idx   = current_PC[IDX_BITS+1:2];
  assign lk_tag   = current_PC[31:IDX_BITS+2];
  assign lk_hit   = valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag);
  assign pc_plus4 = current_PC + 32'd4;

  assign busy          = (state_reg == FLUSH);
  assign predict_taken = (state_reg == IDLE) && lk_hit && ctr_reg[lk_idx][1];
  assign target_addr   = predict_taken ? target_reg[lk_idx] : pc_plus4;

  // Update path
  logic [IDX_BITS-1:0]   upd_idx;
  logic [TAG_BITS-1:0]   upd_tag;
  logic                  upd_hit;
  logic                  upd_accept;
  logic                  upd_we;
  logic [1:0]            upd_ctr_cur;
  logic [1:0]            upd_ctr_w;
  logic [31:0]           upd_target_w;

  assign upd_idx     = update_addr[IDX_BITS+1:2];
  assign upd_tag     = update_addr[31:IDX_BITS+2];
  assign upd_hit     = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);
  assign upd_accept  = update_predictor && (state_reg == IDLE);
  assign upd_ctr_cur = ctr_reg[upd_idx];

  always_comb begin
    upd_we       = 1'b0;
    upd_ctr_w    = upd_ctr_cur;
    upd_target_w = target_reg[upd_idx];
    if (upd_accept) begin
      if (upd_hit) begin
        upd_we = 1'b1;
        if (branch_result) begin
          upd_ctr_w    = (upd_ctr_cur == 2'b11) ? 2'b11 : upd_ctr_cur + 2'b01;
          upd_target_w = update_target;
        end else begin
          upd_ctr_w = (upd_ctr_cur == 2'b00) ? 2'b00 : upd_ctr_cur - 2'b01;
        end
      end else if (branch_result) begin
        // Miss on a taken branch allocates, starting weakly taken
        upd_we       = 1'b1;
        upd_ctr_w    = 2'b10;
        upd_target_w = update_target;
      end
    end
  end

  logic [ENTRIES-1:0] flush_clr;
  logic [ENTRIES-1:0] upd_sel;

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry_sel
      assign flush_clr[gi] = (state_reg == FLUSH) && (flush_idx_reg == IDX_BITS'(gi));
      assign upd_sel[gi]   = upd_we && (upd_idx == IDX_BITS'(gi));
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_reg[i]  <= 1'b0;
        tag_reg[i]    <= '0;
        target_reg[i] <= '0;
        ctr_reg[i]    <= 2'b01;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (flush_clr[i]) begin
          valid_reg[i] <= 1'b0;
        end else if (upd_sel[i]) begin
          valid_reg[i]  <= 1'b1;
          tag_reg[i]    <= upd_tag;
          target_reg[i] <= upd_target_w;
          ctr_reg[i]    <= upd_ctr_w;
        end
      end
    end
  end

  // Flush sequencer
  always_comb begin
    state_next     = state_reg;
    flush_idx_next = flush_idx_reg;
    case (state_reg)
      IDLE: begin
        if (flush_req) begin
          state_next     = FLUSH;
          flush_idx_next = '0;
        end
      end
      FLUSH: begin
        if (flush_idx_reg == IDX_BITS'(ENTRIES - 1)) begin
          state_next     = IDLE;
          flush_idx_next = '0;
        end else begin
          flush_idx_next = flush_idx_reg + 1'b1;
        end
      end
      default: begin
        state_next     = IDLE;
        flush_idx_next = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= IDLE;
      flush_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      flush_idx_reg <= flush_idx_next;
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] lookup_hits_reg;
  logic [31:0] mispredicts_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lookup_hits_reg <= '0;
      mispredicts_reg <= '0;
    end else begin
      if ((state_reg == IDLE) && lk_hit && (lookup_hits_reg != 32'hFFFF_FFFF))
        lookup_hits_reg <= lookup_hits_reg + 32'd1;
      if (upd_accept && (prediction != branch_result) && (mispredicts_reg != 32'hFFFF_FFFF))
        mispredicts_reg <= mispredicts_reg + 32'd1;
    end
  end

  assign lookup_hits = lookup_hits_reg;
  assign mispredicts = mispredicts_reg;
`endif

  // Byte-offset bits and the unused prediction echo carry no table state
  logic unused_bits;
  assign unused_bits = ^{current_PC[1:0], update_addr[1:0], prediction};

endmodule

// File: tb/tb_btb_predictor.sv
// Directed table-driven testbench for btb_predictor (ENTRIES=16): lookup/update vectors plus flush and reset corner cases.
module tb_btb_predictor;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] current_PC;
  logic        predict_taken;
  logic [31:0] target_addr;
  logic        update_predictor;
  logic [31:0] update_addr;
  logic [31:0] update_target;
  logic        prediction;
  logic        branch_result;
  logic        flush_req;
  logic        busy;
`ifdef BTB_STATS_EN
  logic [31:0] lookup_hits;
  logic [31:0] mispredicts;
`endif

  int tests = 0;
  int fails = 0;

  btb_predictor #(.ENTRIES(16)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .current_PC       (current_PC),
    .predict_taken    (predict_taken),
    .target_addr      (target_addr),
    .update_predictor (update_predictor),
    .update_addr      (update_addr),
    .update_target    (update_target),
    .prediction       (prediction),
    .branch_result    (branch_result),
    .flush_req        (flush_req),
    .busy             (busy)
`ifdef BTB_STATS_EN
    ,
    .lookup_hits      (lookup_hits),
    .mispredicts      (mispredicts)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic        upd;
    logic [31:0] ua;
    logic [31:0] ut;
    logic        br;
    logic        exp_pt;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s: %h", name, act);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic upd, input logic [31:0] ua,
                       input logic [31:0] ut, input logic br, input logic fl);
    current_PC       = pc;
    update_predictor = upd;
    update_addr      = ua;
    update_target    = ut;
    branch_result    = br;
    prediction       = 1'b0;
    flush_req        = fl;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_flush(input string name);
    int busy_cnt;
    drive(32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    next_cycle();
    drive(32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      #4;
      if (busy) busy_cnt++;
      next_cycle();
    end
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd16);
  endtask

  initial begin
    int busy_cnt;
    int first_busy;
    int bad;

    vecs[0]  = '{32'h100, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h104};
    vecs[1]  = '{32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 32'h104};
    vecs[2]  = '{32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b1, 32'h200};
    vecs[3]  = '{32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b1, 32'h200};
    vecs[4]  = '{32'h100, 1'b1, 32'h100, 32'h200, 1'b1, 1'b1, 32'h200};
    vecs[5]  = '{32'h100, 1'b1, 32'h100, 32'h200, 1'b0, 1'b1, 32'h200};
    vecs[6]  = '{32'h100, 1'b1, 32'h100, 32'h200, 1'b0, 1'b1, 32'h200};
    vecs[7]  = '{32'h100, 1'b1, 32'h100, 32'h200, 1'b0, 1'b0, 32'h104};
    vecs[8]  = '{32'h100, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h104};
    vecs[9]  = '{32'h100, 1'b1, 32'h100, 32'h200, 1'b0, 1'b0, 32'h104};
    vecs[10] = '{32'h100, 1'b1, 32'h100, 32'h300, 1'b1, 1'b0, 32'h104};
    vecs[11] = '{32'h100, 1'b1, 32'h100, 32'h300, 1'b1, 1'b0, 32'h104};
    vecs[12] = '{32'h100, 1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h300};
    vecs[13] = '{32'h100, 1'b1, 32'h140, 32'h500, 1'b1, 1'b1, 32'h300};
    vecs[14] = '{32'h100, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h104};
    vecs[15] = '{32'h140, 1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h500};
    vecs[16] = '{32'h208, 1'b1, 32'h208, 32'h600, 1'b0, 1'b0, 32'h20C};
    vecs[17] = '{32'h208, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h20C};
    vecs[18] = '{32'h208, 1'b1, 32'h208, 32'h40,  1'b1, 1'b0, 32'h20C};
    vecs[19] = '{32'h20B, 1'b0, 32'h0,   32'h0,   1'b0, 1'b1, 32'h40};
    vecs[20] = '{32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 32'h80, 1'b1, 1'b0, 32'h0};
    vecs[21] = '{32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h80};
    vecs[22] = '{32'hFFFF_FFF8, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFC};
    vecs[23] = '{32'h140, 1'b1, 32'h140, 32'h500, 1'b0, 1'b1, 32'h500};
    vecs[24] = '{32'h140, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h144};

    RST = 1'b1;
    drive(32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    #3;
    check("reset_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].pc, vecs[i].upd, vecs[i].ua, vecs[i].ut, vecs[i].br, 1'b0);
      prediction = vecs[i].exp_pt;
      #3;
      check($sformatf("vec%0d_taken", i), 32'(predict_taken), 32'(vecs[i].exp_pt));
      check($sformatf("vec%0d_target", i), target_addr, vecs[i].exp_tgt);
      next_cycle();
    end

    // Fill every entry with a taken branch, then flush
    for (int i = 0; i < 16; i++) begin
      drive(32'h0, 1'b1, 32'h1000 + 32'(4 * i), 32'h2000 + 32'(4 * i), 1'b1, 1'b0);
      next_cycle();
    end
    drive(32'h1014, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    #3;
    check("prefill_taken", 32'(predict_taken), 32'd1);
    check("prefill_target", target_addr, 32'h2014);
    check("busy_on_req_cycle", 32'(busy), 32'd0);
    next_cycle();

    busy_cnt = 0; first_busy = -1; bad = 0;
    for (int c = 0; c < 40; c++) begin
      drive(32'h1000 + 32'(4 * (c % 16)), (c == 5), 32'h1000, 32'h9000, 1'b1, (c == 8));
      #3;
      if (busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = c;
        if (predict_taken || (target_addr != current_PC + 32'd4)) bad++;
      end
      next_cycle();
    end
    check("flush_busy_cycles", 32'(busy_cnt), 32'd16);
    check("flush_first_busy", 32'(first_busy), 32'd0);
    check("flush_lookups_forced_nt", 32'(bad), 32'd0);

    bad = 0;
    for (int i = 0; i < 16; i++) begin
      drive(32'h1000 + 32'(4 * i), 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      #1;
      if (predict_taken || (target_addr != current_PC + 32'd4)) bad++;
    end
    check("post_flush_all_nt", 32'(bad), 32'd0);
    drive(32'h1000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("dropped_update_taken", 32'(predict_taken), 32'd0);
    check("dropped_update_target", target_addr, 32'h1004);
    next_cycle();

    // Reset asserted mid-flush
    drive(32'h0, 1'b1, 32'h1028, 32'h7000, 1'b1, 1'b0);
    next_cycle();
    drive(32'h1028, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    #3;
    check("rst_prefill_taken", 32'(predict_taken), 32'd1);
    next_cycle();
    drive(32'h1028, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (4) next_cycle();
    #2;
    check("midflush_busy_before_rst", 32'(busy), 32'd1);
    RST = 1'b1;
    #1;
    check("midflush_rst_busy", 32'(busy), 32'd0);
    check("midflush_rst_taken", 32'(predict_taken), 32'd0);
    check("midflush_rst_target", target_addr, 32'h102C);
    next_cycle();
    RST = 1'b0;
    #3;
    check("after_rst_busy", 32'(busy), 32'd0);
    check("after_rst_taken", 32'(predict_taken), 32'd0);
    next_cycle();
    run_flush("post_rst_flush");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters. It implements the predictor side of the fetch-stage predictor interface.
- Fetch presents current_PC each cycle and receives predict_taken / target_addr combinationally in the same cycle.
- Execute reports resolved branches through the update port.
- A sequential flush engine invalidates the table one entry per cycle on request, for fence.i or context-switch use.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, minimum 2.
- IDX_BITS, log2(ENTRIES), index width; derived, not overridden.
- TAG_BITS, 30-IDX_BITS, tag width; derived.

Ports:
- CLK  input  1  core clock, rising edge
- RST  input  1  asynchronous reset, active-high
- current_PC  input  32  fetch PC to predict
- predict_taken  output  1  1 = redirect fetch to target_addr
- target_addr  output  32  predicted next PC
- update_predictor  input  1  resolved-branch update strobe
- update_addr  input  32  PC of resolved branch
- update_target  input  32  resolved branch target
- prediction  input  1  what was predicted for this branch
- branch_result  input  1  1 = branch actually taken
- flush_req  input  1  single-cycle request to invalidate table
- busy  output  1  flush in progress

Behaviour:
- Clock and reset: one clock (CLK); reset RST is asynchronous and active-high.
- Addressing:
  - index = addr[IDX_BITS+1:2]; tag = addr[31:IDX_BITS+2].
  - addr[1:0] is ignored.
- Per-entry state: valid (1), tag (TAG_BITS), target (32), ctr (2).
- Reset values:
  - All valid=0, ctr=2'b01 (weakly not-taken), target=0, tag=0.
  - FSM=IDLE, flush index=0, busy=0.
  - Outputs: predict_taken=0, target_addr=current_PC+4.
- Lookup (combinational, zero latency):
  - hit = valid[idx] & (tag[idx]==PC tag).
  - predict_taken = hit & ctr[idx][1].
  - target_addr = predict_taken ? target[idx] : current_PC+4 (32-bit wrap; 0xFFFFFFFC+4 = 0).
- Update (registered, visible to lookup the cycle after the strobe):
  - Acted on only when update_predictor=1 and FSM=IDLE.
  - Hit, taken: ctr = min(ctr+1, 3); target = update_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate/overwrite entry: valid=1, tag, target, ctr=2'b10.
  - Miss, not taken: no change.
  - prediction is not used for table state.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents (no bypass).
- FSM:
  - IDLE: flush_req=1 -> FLUSH, flush index=0, busy=1 from the next cycle.
  - FLUSH: each cycle clear valid[flush index] and increment the index. When the index reaches ENTRIES-1, clear that entry and return to IDLE (busy=0 the following cycle). Total flush = ENTRIES cycles.
  - During FLUSH: predict_taken forced 0, target_addr=current_PC+4, update_predictor ignored, flush_req ignored.
  - flush_req and update_predictor in the same IDLE cycle: update is applied, then FLUSH starts next cycle.
- Reset mid-flush: immediate return to reset values; no partial state retained.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined:
  - Adds outputs lookup_hits (32) and mispredicts (32), both reset to 0, saturating at 0xFFFFFFFF.
  - lookup_hits increments every IDLE cycle where hit=1.
  - mispredicts increments on each accepted update where prediction != branch_result.
  - Both counters hold during FLUSH.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then current_PC=0x100 -> predict_taken=0, target_addr=0x104, busy=0.
- Update taken 0x100->0x200, then PC=0x100 -> predict_taken=1, target_addr=0x200.
- Three more taken updates, then three not-taken updates at 0x100:
  - ctr sequence 2 (after allocate) -> 3, 3, 3 -> 2, 1, 0.
  - predict_taken=1 through ctr=2, then 0 at ctr=1 and ctr=0.
- Aliasing (ENTRIES=16): allocate 0x100, then taken update 0x140 (same index 0) -> PC=0x100 predicts 0/0x104; PC=0x140 predicts 1.
- Flush:
  - Fill entries 0..15 with taken branches, then pulse flush_req.
  - busy=1 for exactly 16 cycles; all lookups predict not-taken during and after.
  - An update during the flush is dropped.
- Assert RST during flush cycle 5 -> busy=0 immediately, all lookups not-taken; flush_req after release runs a full 16-cycle flush.
